// File: rtl/core_fetch_pkg.sv
// Shared types for the instruction-fetch front end: IF/ID register payload and
// the instruction-buffer entry.
package core_fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            valid;
  } IF_regs_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// Generic synchronous FIFO with count; push while full is legal only together with pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];
  assign w_pop     = pop && !empty;
  assign w_push    = push && (!full || w_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  a_no_overflow : assert property (@(posedge clock) disable iff (reset || clear)
    !(push && full && !pop)) else $error("fetch_fifo overflow");
  a_no_underflow : assert property (@(posedge clock) disable iff (reset || clear)
    !(pop && empty)) else $error("fetch_fifo underflow");

endmodule

// File: rtl/core_fetch.sv
// Instruction-fetch front end: PC register, credit-limited imem requests, address
// queue for in-flight PCs and an instruction buffer feeding IF/ID; flush drops stale responses.
module core_fetch
  import core_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] next_fetch_pc,
  input  logic        flush,
  input  logic        stall,
  output logic [63:0] fetch_pc4,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        IF_valid,
  output logic [31:0] IF_inst,
  output logic [63:0] IF_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = $bits(fetch_entry_t);

  logic [63:0]  r_pc;
  logic [CW-1:0] r_drop;

  logic [63:0]  w_aq_head;
  logic [CW-1:0] w_aq_count;
  logic [CW-1:0] w_ib_count;
  logic         w_aq_full;
  logic         w_aq_empty;
  logic         w_ib_full;
  logic         w_ib_empty;
  logic [CW:0]  w_credits;
  logic         w_fire;
  logic         w_resp;
  logic         w_ib_push;
  logic         w_ib_pop;
  fetch_entry_t w_ib_in;
  fetch_entry_t w_ib_head;
  IF_regs_t     w_if;

  // The address queue occupancy is the outstanding-request count.
  assign w_credits      = (CW+1)'(w_aq_count) + (CW+1)'(w_ib_count);
  assign imem_req_valid = !reset && !flush && !w_aq_full && (w_credits < (CW+1)'(DEPTH));
  assign w_fire         = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = r_pc;
  assign fetch_pc4      = pc_plus4(r_pc);

  assign w_resp    = imem_resp_valid && !w_aq_empty;
  assign w_ib_push = w_resp && !flush && (r_drop == '0) && (!w_ib_full || w_ib_pop);
  assign w_ib_pop  = !w_ib_empty && !stall && !flush;
  assign w_ib_in   = '{pc: w_aq_head, inst: imem_resp_data};

  assign w_if     = '{pc: w_ib_head.pc, inst: w_ib_head.inst, valid: !w_ib_empty};
  assign IF_valid = w_if.valid;
  assign IF_inst  = w_if.inst;
  assign IF_pc    = w_if.pc;

  // On flush every response still owed by memory becomes stale.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc   <= RESET_PC;
      r_drop <= '0;
    end else begin
      if (flush || w_fire) r_pc <= next_fetch_pc;
      if (flush) begin
        r_drop <= w_aq_count - CW'(w_resp);
      end else if (w_resp && (r_drop != '0)) begin
        r_drop <= r_drop - CW'(1);
      end
    end
  end

  fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_addr_q (
    .clock     (clock),
    .reset     (reset),
    .clear     (1'b0),
    .push      (w_fire),
    .push_data (r_pc),
    .pop       (w_resp),
    .head_data (w_aq_head),
    .full      (w_aq_full),
    .empty     (w_aq_empty),
    .count     (w_aq_count)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_inst_buf (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (w_ib_push),
    .push_data (w_ib_in),
    .pop       (w_ib_pop),
    .head_data (w_ib_head),
    .full      (w_ib_full),
    .empty     (w_ib_empty),
    .count     (w_ib_count)
  );

endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: queue-based reference model with staleness tags, a variable-latency
// memory, a pc4 vector table, directed corner sequences and a randomized run.
module tb_core_fetch;
  import core_fetch_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] next_fetch_pc;
  logic        flush;
  logic        stall;
  logic [63:0] fetch_pc4;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        IF_valid;
  logic [31:0] IF_inst;
  logic [63:0] IF_pc;

  always #5 clock = ~clock;

  core_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock           (clock),
    .reset           (reset),
    .next_fetch_pc   (next_fetch_pc),
    .flush           (flush),
    .stall           (stall),
    .fetch_pc4       (fetch_pc4),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .IF_valid        (IF_valid),
    .IF_inst         (IF_inst),
    .IF_pc           (IF_pc)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: in-flight requests tagged stale by a flush, buffer as a plain queue.
  typedef struct { logic [63:0] addr; bit stale; } infl_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } bufe_t;
  typedef struct { logic [63:0] addr; int due; } memq_t;
  infl_t       m_infl[$];
  bufe_t       m_buf[$];
  logic [63:0] m_pc = RESET_PC;
  memq_t       mq[$];
  int          last_due = 0;
  int          mem_lat  = 1;
  bit          rand_lat = 1'b0;
  bit          chk_en   = 1'b0;

  bit          obs_valid;
  bit          obs_ifv;
  logic [63:0] obs_addr;
  logic [63:0] obs_pc4;
  logic [63:0] obs_ifpc;
  int          obs_cyc;
  logic [63:0] obs_req[$];
  logic [63:0] obs_if[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic run_cycle(input bit rst, input bit fl, input logic [63:0] tgt,
                           input bit stl, input bit rdy);
    bit    resp;
    bit    exp_valid;
    bit    fire;
    bit    have_new;
    bufe_t newent;
    infl_t e;
    int    lat;
    int    due;
    @(negedge clock);
    reset          = rst;
    flush          = fl;
    stall          = stl;
    imem_req_ready = rdy;
    next_fetch_pc  = fl ? tgt : m_pc + 64'd4;
    resp           = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(mq[0].addr) : 32'($urandom);
    #2;
    exp_valid = !rst && !fl && (m_infl.size() + m_buf.size() < DEPTH);
    if (chk_en) begin
      check64("req_valid", 64'(imem_req_valid), 64'(exp_valid));
      check64("req_addr", imem_req_addr, m_pc);
      check64("fetch_pc4", fetch_pc4, m_pc + 64'd4);
      check64("IF_valid", 64'(IF_valid), 64'(m_buf.size() > 0));
      if (m_buf.size() > 0) begin
        check64("IF_pc", IF_pc, m_buf[0].pc);
        check64("IF_inst", 64'(IF_inst), 64'(m_buf[0].inst));
      end
    end
    obs_valid = imem_req_valid;
    obs_ifv   = IF_valid;
    obs_addr  = imem_req_addr;
    obs_pc4   = fetch_pc4;
    obs_ifpc  = IF_pc;
    obs_cyc   = cyc;
    if (imem_req_valid && rdy) obs_req.push_back(imem_req_addr);
    if (IF_valid && !stl && !fl && !rst) obs_if.push_back(IF_pc);
    fire = exp_valid && rdy;
    if (rst) begin
      m_pc = RESET_PC;
      m_infl.delete();
      m_buf.delete();
      mq.delete();
      last_due = cyc;
    end else begin
      have_new = 1'b0;
      if (resp) begin
        mq.pop_front();
        e = m_infl.pop_front();
        if (!fl && !e.stale) begin
          newent   = '{pc: e.addr, inst: mem_word(e.addr)};
          have_new = 1'b1;
        end
      end
      if (m_buf.size() > 0 && !stl && !fl) void'(m_buf.pop_front());
      if (fl) begin
        m_buf.delete();
        foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      end
      if (have_new) m_buf.push_back(newent);
      if (fire) begin
        m_infl.push_back('{addr: m_pc, stale: 1'b0});
        lat = rand_lat ? int'($urandom_range(4, 1)) : mem_lat;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{addr: m_pc, due: due});
      end
      if (fl || fire) m_pc = next_fetch_pc;
    end
    if (rst) chk_en = 1'b1;
    cyc++;
  endtask

  typedef struct { logic [63:0] tgt; logic [63:0] exp_pc4; } vec_t;
  vec_t vecs[5];

  initial begin
    int          first_fire;
    int          first_if;
    int          gaps;
    logic [63:0] base;
    logic [63:0] head_at_stall;

    vecs[0] = '{tgt: 64'hFFFF_FFFF_FFFF_FFFC, exp_pc4: 64'h0};
    vecs[1] = '{tgt: 64'h0000_0000_0000_0103, exp_pc4: 64'h0000_0000_0000_0107};
    vecs[2] = '{tgt: 64'h7FFF_FFFF_FFFF_FFFE, exp_pc4: 64'h8000_0000_0000_0002};
    vecs[3] = '{tgt: 64'h0000_0000_0000_0100, exp_pc4: 64'h0000_0000_0000_0104};
    vecs[4] = '{tgt: 64'hFFFF_FFFF_FFFF_FFFF, exp_pc4: 64'h0000_0000_0000_0003};

    reset = 1'b1; flush = 1'b0; stall = 1'b0; imem_req_ready = 1'b0;
    next_fetch_pc = '0; imem_resp_valid = 1'b0; imem_resp_data = '0;

    // Reset, then 1-cycle memory: back-to-back requests and continuous IF_valid.
    mem_lat = 1;
    run_cycle(1, 0, 0, 0, 1);
    run_cycle(1, 0, 0, 0, 1);
    check64("reset_IF_valid", 64'(IF_valid), 64'(0));
    check64("reset_req_addr", imem_req_addr, RESET_PC);
    obs_req.delete();
    first_fire = -1; first_if = -1; gaps = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle(0, 0, 0, 0, 1);
      if (obs_valid && first_fire < 0) first_fire = obs_cyc;
      if (first_if >= 0 && !obs_ifv) gaps++;
      if (obs_ifv && first_if < 0 && obs_ifpc == 64'h0) first_if = obs_cyc;
    end
    check64("first_if_latency", 64'(first_if - first_fire), 64'(2));
    check64("if_valid_gaps", 64'(gaps), 64'(0));
    check64("req_count", 64'(obs_req.size() >= 3), 64'(1));
    if (obs_req.size() >= 3) begin
      check64("req0", obs_req[0], 64'h0);
      check64("req1", obs_req[1], 64'h4);
      check64("req2", obs_req[2], 64'h8);
    end

    // Stall six cycles: credits run out; release drains in order.
    obs_req.delete();
    for (int i = 0; i < 6; i++) run_cycle(0, 0, 0, 1, 1);
    head_at_stall = obs_ifpc;
    check64("stall_req_valid", 64'(obs_valid), 64'(0));
    check64("stall_fires_le_credits", 64'(obs_req.size() <= DEPTH), 64'(1));
    obs_if.delete();
    for (int i = 0; i < 8; i++) run_cycle(0, 0, 0, 0, 1);
    check64("drain_count", 64'(obs_if.size() >= 4), 64'(1));
    if (obs_if.size() >= 4) begin
      check64("drain_head", obs_if[0], head_at_stall);
      for (int k = 0; k < 3; k++) check64("drain_order", obs_if[k+1], obs_if[k] + 64'd4);
    end

    // 3-cycle memory, two outstanding, flush to 0x100.
    mem_lat = 3;
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 1);
    run_cycle(0, 0, 0, 0, 1);
    run_cycle(0, 1, 64'h100, 0, 1);
    obs_if.delete();
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 0, 0, 1);
    check64("flush_late_count", 64'(obs_if.size() > 0), 64'(1));
    if (obs_if.size() > 0) check64("flush_late_first", obs_if[0], 64'h100);

    // Flush coincident with a response and a valid head.
    mem_lat = 1;
    for (int i = 0; i < 5; i++) run_cycle(0, 0, 0, 0, 1);
    run_cycle(0, 1, 64'h200, 0, 1);
    check64("flush_head_valid", 64'(obs_ifv), 64'(1));
    obs_if.delete();
    run_cycle(0, 0, 0, 0, 1);
    check64("flush_buf_empty", 64'(obs_ifv), 64'(0));
    for (int i = 0; i < 6; i++) run_cycle(0, 0, 0, 0, 1);
    check64("flush_coinc_count", 64'(obs_if.size() > 0), 64'(1));
    if (obs_if.size() > 0) check64("flush_coinc_first", obs_if[0], 64'h200);

    // Memory not ready: address and pc4 hold.
    run_cycle(0, 0, 0, 0, 0);
    base = obs_addr;
    for (int i = 0; i < 5; i++) begin
      run_cycle(0, 0, 0, 0, 0);
      check64("hold_addr", obs_addr, base);
      check64("hold_pc4", obs_pc4, base + 64'd4);
    end

    // Reset with two requests outstanding.
    mem_lat = 3;
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 1);
    run_cycle(0, 0, 0, 0, 1);
    run_cycle(1, 0, 0, 0, 1);
    run_cycle(0, 0, 0, 0, 1);
    check64("rst_mid_IF_valid", 64'(obs_ifv), 64'(0));
    check64("rst_mid_req_valid", 64'(obs_valid), 64'(1));
    check64("rst_mid_req_addr", obs_addr, RESET_PC);
    for (int i = 0; i < 6; i++) run_cycle(0, 0, 0, 0, 1);

    // pc4 vector table, including wrap and misaligned targets.
    for (int v = 0; v < 5; v++) begin
      run_cycle(0, 1, vecs[v].tgt, 0, 0);
      run_cycle(0, 0, 0, 0, 0);
      check64("vec_addr", obs_addr, vecs[v].tgt);
      check64("vec_pc4", obs_pc4, vecs[v].exp_pc4);
    end

    // Randomized traffic against the model.
    rand_lat = 1'b1;
    run_cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] tgt;
      tgt = {32'($urandom), 32'($urandom)};
      if ($urandom_range(1, 0) == 0) tgt = {32'h0, 16'h0, 16'($urandom)} & ~64'h3;
      run_cycle($urandom_range(99, 0) == 0, $urandom_range(19, 0) == 0, tgt,
                $urandom_range(2, 0) == 0, $urandom_range(3, 0) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_fetch.md
# core_fetch

Instruction-fetch front end of the pipelined core. Holds the fetch PC, issues in-order word requests to instruction memory over a valid/ready request channel, and buffers returned instructions for the IF/ID register. Consumes `next_fetch_pc`/`flush` from the branch/next-PC unit and feeds `fetch_pc4` back to it. After a redirect it discards every in-flight response so that no stale instruction reaches ID.

## Interface
- `DEPTH`, 4: total fetch credits (outstanding requests plus buffered instructions); power of two, ≥2.
- `RESET_PC`, 64'h0: PC loaded on reset.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `next_fetch_pc` input 64: PC selected by the branch unit; equals `fetch_pc4` when not redirecting.
- `flush` input 1: redirect; load `next_fetch_pc`, drop all buffered and in-flight instructions.
- `stall` input 1: ID cannot accept an instruction this cycle.
- `fetch_pc4` output 64: `pc + 4` (mod 2^64), combinational from the PC register.
- `imem_req_valid` output 1: request valid.
- `imem_req_ready` input 1: memory accepts request.
- `imem_req_addr` output 64: equals `pc`.
- `imem_resp_valid` input 1: one in-order response word.
- `imem_resp_data` input 32: instruction word.
- `IF_valid` output 1: buffer head valid.
- `IF_inst` output 32: head instruction.
- `IF_pc` output 64: address of head instruction.

## Operation
- State: `pc`, address queue (PCs of outstanding requests), instruction buffer (inst+pc), `outstanding` and `drop` counters, each `$clog2(DEPTH+1)` bits.
- Request: `imem_req_valid = !reset && !flush && (outstanding + count < DEPTH)`. Uses registered counts only, with no combinational path from `stall`. Fire = valid && ready.
- On fire without flush: `pc <= next_fetch_pc`, push `pc` into the address queue, `outstanding++`.
- On flush: `pc <= next_fetch_pc`. Clear the instruction buffer. Set `drop <= outstanding − (resp this cycle)`. Issue no request that cycle.
- Response with `drop > 0`: discard, `drop--`, pop the address queue, `outstanding--`.
- Response with `drop == 0` and no flush: push {data, popped address} into the buffer, `outstanding--`. Space is guaranteed by the credit rule; overflow is an assertion failure.
- Pop the buffer when `IF_valid && !stall && !flush`.
- Simultaneous push and pop on the buffer is legal in the same cycle, including when the buffer is full.
- Reset: `pc = RESET_PC`; buffers empty; `outstanding = drop = 0`; `imem_req_valid = 0`; `IF_valid = 0`. Instruction memory shares `reset` and discards its in-flight requests.
- Reset mid-operation takes priority over flush, response, and fire.
- Misaligned PC is passed through unchanged; alignment faults are detected downstream.

## Timing
- Request accepted at cycle t. Response arrives at t+1 or later. `IF_valid` asserts at response cycle + 1 (the buffer is registered, with no bypass).
- With a 1-cycle memory and `DEPTH=4`, throughput is one instruction per cycle in steady state.
- Flush asserted at cycle f: the new PC is requested at f+1. Nothing fetched before f is ever presented after f.
- Responses arriving during or after a flush are counted against `drop` in order; a second flush while `drop>0` recomputes `drop` from `outstanding`.
- Pointers wrap modulo `DEPTH`; `count` distinguishes full from empty.
- `fetch_pc4` wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.

## Structure
- `structures` package gains `IF_regs_t` {pc[63:0], inst[31:0], valid} for the IF/ID register. `RESET_PC` stays a parameter.
- Sub-module `fetch_fifo` is a generic synchronous FIFO (WIDTH, DEPTH; push, pop, full, empty, count). It is instantiated twice: once as the address queue and once as the instruction buffer.

## Test plan
- Reset, then idle memory with ready=1 and 1-cycle response: requests 0, 4, 8 on consecutive cycles; `IF_pc`=0 appears 2 cycles after the first request; `IF_valid` stays high continuously.
- `stall` held high for 6 cycles: at most 4 credits are used, then `imem_req_valid`=0. On release, instructions drain in order 0, 4, 8, 12 with no loss.
- Memory with 3-cycle latency, 2 outstanding, flush to 0x100: the 2 late responses are dropped; the next `IF_pc`=0x100.
- Flush coincident with a response and with `IF_valid`: the head is not popped downstream, the buffer is empties, the response is discarded, and `drop`=outstanding−1.
- `imem_req_ready`=0 for 5 cycles: `imem_req_addr` and `pc` stay stable; `fetch_pc4` = addr+4.
- Reset asserted with 2 requests outstanding: the next cycle shows `IF_valid`=0 and a request to `RESET_PC`.
